pulse_transmitter_job_scheduler: RTL and testbench
==================================================

// Module: pulse_transmitter_job_scheduler
// PURPOSE
//  Queues transmit jobs and sequences the pulse transmitter: loads per-job end count/prescaler,
//  raises start, waits for completion, repeats with programmable gap, raises interrupt on finish.
//  Sits between the TinyQV register interface and the pulse transmitter core, so software
//  issues bursts without polling between runs.
// PARAMETERS
//  DEPTH            4         job FIFO entries (power of 2, >=2)
//  WATCHDOG_CYCLES  20'hFFFFF WAIT_DONE timeout in clk cycles (used only with macro)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, synchronous, active-low
//  job_valid      in   1   job word offered
//  job_data       in   32  [6:0] end_count, [10:7] prescaler, [14:11] repeats (0=once), [30:15] gap, [31] irq_en
//  job_ready      out  1   FIFO can accept (level<DEPTH)
//  abort          in   1   flush queue, stop current job
//  tx_start       out  1   level start to transmitter (runs on rising edge)
//  tx_end_count   out  7   program end count for current job
//  tx_prescaler   out  4   main prescaler for current job
//  tx_done        in   1   1-cycle pulse: transmitter output returned to idle
//  busy           out  1   state != IDLE
//  queue_level    out  $clog2(DEPTH)+1  FIFO occupancy
//  irq            out  1   sticky completion/error interrupt
//  irq_clear      in   1   clears irq
//  watchdog_err   out  1   sticky timeout flag (0 when macro absent)
// BEHAVIOUR
//  Reset: tx_start/tx_end_count/tx_prescaler/busy/irq/watchdog_err/queue_level=0; state IDLE;
//   job_ready=1 from first cycle after reset.
//  Push on job_valid&&job_ready; job_ready from registered level, so full+pop same cycle = no push.
//  FSM:
//   IDLE: level>0 -> pop head into job regs (repeats_left=repeats), -> LOAD.
//   LOAD: tx_end_count/tx_prescaler driven from job regs, tx_start=0 -> START.
//   START: tx_start<=1 -> WAIT_DONE.
//   WAIT_DONE: tx_done&&repeats_left==0 -> tx_start<=0, irq<=1 if irq_en, -> IDLE.
//              tx_done&&repeats_left>0 -> tx_start<=0, repeats_left-1, gap_cnt<=gap -> GAP.
//   GAP: gap_cnt==0 -> START, else decrement; gap=0 gives 1 cycle tx_start low (edge guaranteed).
//  Latency: handshake into empty idle scheduler at edge N -> tx_start high after edge N+3.
//  Gap: tx_start low for gap+1 cycles between repeats; low >=1 cycle between jobs (IDLE+LOAD).
//  tx_done outside WAIT_DONE ignored. tx_end_count/prescaler stable from LOAD until next pop.
//  abort (any state): next cycle tx_start=0, FIFO flushed (level=0), job discarded, IDLE;
//   abort beats simultaneous push (dropped) and tx_done (no irq); irq not cleared by abort.
//  irq set has priority over simultaneous irq_clear. Gap counter 16-bit, no wrap.
// CONFIGURATION
//  PULSE_SCHED_WATCHDOG_EN defined: 20-bit counter runs in WAIT_DONE, cleared on entry;
//   reaching WATCHDOG_CYCLES without tx_done -> tx_start=0, remaining repeats dropped,
//   watchdog_err<=1, irq<=1 (regardless of irq_en), -> IDLE; queue continues next job.
//   watchdog_err cleared by irq_clear (same priority rule).
//  Undefined: no counter, watchdog_err tied 0, WATCHDOG_CYCLES unused.
// STRUCTURE
//  pulse_transmitter_pkg: state encoding (IDLE/LOAD/START/WAIT_DONE/GAP), job_data field
//   bit-position localparams, default DEPTH.
//  Sub-module pulse_transmitter_job_fifo: DEPTH x 32 sync FIFO, push/pop/flush, level out,
//   head data combinational. Scheduler FSM, repeat/gap/watchdog counters in top.
// TESTING
//  1 job end=5,presc=2,rep=0,irq_en=1; tx_done 10 cycles after start -> tx_start high
//    3 cycles after push, low after done, irq=1, busy=0, tx_end_count=5.
//  2 rep=2,gap=4 -> exactly 3 tx_start rising edges, each low period 5 cycles, one irq.
//  3 Push 5 jobs with DEPTH=4 while busy -> 5th sees job_ready=0 until a pop; jobs run in order.
//  4 abort mid-WAIT_DONE with 3 queued + push same cycle -> tx_start=0, level=0, IDLE, no irq.
//  5 irq_clear same cycle as completion -> irq stays 1; clear later -> 0; rep=0,gap=0 edge check.
//  6 (macro) WATCHDOG_CYCLES=100, no tx_done -> after 100 cycles watchdog_err=1, irq=1, next job
//    starts; without macro watchdog_err stays 0 and WAIT_DONE holds.

Source files
------------

// File: rtl/pulse_transmitter_pkg.sv
// Shared types for the pulse transmitter job scheduler: FSM states, job word layout, default depth.
package pulse_transmitter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   localparam int DEPTH_DEFAULT = 4;

   localparam int END_LSB    = 0;
   localparam int END_W      = 7;
   localparam int PRESC_LSB  = 7;
   localparam int PRESC_W    = 4;
   localparam int REP_LSB    = 11;
   localparam int REP_W      = 4;
   localparam int GAP_LSB    = 15;
   localparam int GAP_W      = 16;
   localparam int IRQ_EN_BIT = 31;

   typedef struct packed {
      logic                irq_en;
      logic [GAP_W-1:0]    gap;
      logic [REP_W-1:0]    repeats;
      logic [PRESC_W-1:0]  prescaler;
      logic [END_W-1:0]    end_count;
   } job_t;

   function automatic job_t unpack_job(input logic [31:0] w);
      job_t j;
      j.end_count = w[END_LSB +: END_W];
      j.prescaler = w[PRESC_LSB +: PRESC_W];
      j.repeats   = w[REP_LSB +: REP_W];
      j.gap       = w[GAP_LSB +: GAP_W];
      j.irq_en    = w[IRQ_EN_BIT];
      return j;
   endfunction

endpackage

// File: rtl/pulse_transmitter_job_fifo.sv
// DEPTH x 32 synchronous job FIFO with flush; head word is presented combinationally.
module pulse_transmitter_job_fifo
   import pulse_transmitter_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic [31:0]               push_data,
   input  logic                      pop,
   input  logic                      flush,
   output logic [31:0]               head_data,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          do_push, do_pop;

   always_comb begin
      do_push  = push && !flush && (level_q < (AW+1)'(DEPTH));
      do_pop   = pop && !flush && (level_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign level     = level_q;

endmodule

// File: rtl/pulse_transmitter_job_scheduler.sv
// Job scheduler for the pulse transmitter: queues jobs, sequences start/done with repeats and gaps.
// Optional WAIT_DONE watchdog enabled by defining PULSE_SCHED_WATCHDOG_EN.
//
//  state      | meaning
//  IDLE       | waiting for a queued job, pops head when level>0
//  LOAD       | drive end count / prescaler from job regs, tx_start low
//  START      | raise tx_start
//  WAIT_DONE  | wait for tx_done (watchdog runs here when enabled)
//  GAP        | tx_start low for gap+1 cycles between repeats
module pulse_transmitter_job_scheduler
   import pulse_transmitter_pkg::*;
#(
   parameter int          DEPTH           = DEPTH_DEFAULT,
   parameter logic [19:0] WATCHDOG_CYCLES = 20'hFFFFF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      job_valid,
   input  logic [31:0]               job_data,
   output logic                      job_ready,
   input  logic                      abort,
   output logic                      tx_start,
   output logic [6:0]                tx_end_count,
   output logic [3:0]                tx_prescaler,
   input  logic                      tx_done,
   output logic                      busy,
   output logic [$clog2(DEPTH):0]    queue_level,
   output logic                      irq,
   input  logic                      irq_clear,
   output logic                      watchdog_err
);

   localparam int LW = $clog2(DEPTH) + 1;

   state_t        state_q, state_d;
   job_t          job_q, job_d;
   logic [3:0]    repeats_left_q, repeats_left_d;
   logic [15:0]   gap_cnt_q, gap_cnt_d;
   logic          tx_start_q, tx_start_d;
   logic [6:0]    end_count_q, end_count_d;
   logic [3:0]    prescaler_q, prescaler_d;
   logic          irq_q, irq_d;
   logic          irq_set, wd_set;
   logic          push, pop;
   logic [31:0]   head_data;
   logic [LW-1:0] fifo_level;
   job_t          head_job;

`ifdef PULSE_SCHED_WATCHDOG_EN
   logic [19:0]   wd_cnt_q, wd_cnt_d;
   logic          wd_err_q, wd_err_d;
`endif

   assign job_ready = (fifo_level < LW'(DEPTH));
   assign push      = job_valid && job_ready;
   assign head_job  = unpack_job(head_data);

   pulse_transmitter_job_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (job_data),
      .pop       (pop),
      .flush     (abort),
      .head_data (head_data),
      .level     (fifo_level)
   );

   always_comb begin
      state_d        = state_q;
      job_d          = job_q;
      repeats_left_d = repeats_left_q;
      gap_cnt_d      = gap_cnt_q;
      tx_start_d     = tx_start_q;
      end_count_d    = end_count_q;
      prescaler_d    = prescaler_q;
      pop            = 1'b0;
      irq_set        = 1'b0;
      wd_set         = 1'b0;
`ifdef PULSE_SCHED_WATCHDOG_EN
      wd_cnt_d       = wd_cnt_q;
`endif
      // abort outranks everything, including a tx_done in the same cycle
      if (abort) begin
         state_d    = ST_IDLE;
         tx_start_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fifo_level != '0) begin
                  pop            = 1'b1;
                  job_d          = head_job;
                  repeats_left_d = head_job.repeats;
                  state_d        = ST_LOAD;
               end
            end
            ST_LOAD: begin
               end_count_d = job_q.end_count;
               prescaler_d = job_q.prescaler;
               tx_start_d  = 1'b0;
               state_d     = ST_START;
            end
            ST_START: begin
               tx_start_d = 1'b1;
               state_d    = ST_WAIT_DONE;
`ifdef PULSE_SCHED_WATCHDOG_EN
               wd_cnt_d   = '0;
`endif
            end
            ST_WAIT_DONE: begin
               if (tx_done) begin
                  tx_start_d = 1'b0;
                  if (repeats_left_q == '0) begin
                     irq_set = job_q.irq_en;
                     state_d = ST_IDLE;
                  end else begin
                     repeats_left_d = repeats_left_q - 4'd1;
                     gap_cnt_d      = job_q.gap;
                     state_d        = ST_GAP;
                  end
               end
`ifdef PULSE_SCHED_WATCHDOG_EN
               else if (wd_cnt_q == WATCHDOG_CYCLES - 20'd1) begin
                  tx_start_d = 1'b0;
                  irq_set    = 1'b1;
                  wd_set     = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  wd_cnt_d = wd_cnt_q + 20'd1;
               end
`endif
            end
            ST_GAP: begin
               // restart straight from GAP so gap=0 still yields a one-cycle low
               if (gap_cnt_q == '0) begin
                  tx_start_d = 1'b1;
                  state_d    = ST_WAIT_DONE;
`ifdef PULSE_SCHED_WATCHDOG_EN
                  wd_cnt_d   = '0;
`endif
               end else begin
                  gap_cnt_d = gap_cnt_q - 16'd1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      irq_d = irq_set ? 1'b1 : (irq_clear ? 1'b0 : irq_q);
`ifdef PULSE_SCHED_WATCHDOG_EN
      wd_err_d = wd_set ? 1'b1 : (irq_clear ? 1'b0 : wd_err_q);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         job_q          <= '0;
         repeats_left_q <= '0;
         gap_cnt_q      <= '0;
         tx_start_q     <= 1'b0;
         end_count_q    <= '0;
         prescaler_q    <= '0;
         irq_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         job_q          <= job_d;
         repeats_left_q <= repeats_left_d;
         gap_cnt_q      <= gap_cnt_d;
         tx_start_q     <= tx_start_d;
         end_count_q    <= end_count_d;
         prescaler_q    <= prescaler_d;
         irq_q          <= irq_d;
      end
   end

`ifdef PULSE_SCHED_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt_q <= '0;
         wd_err_q <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         wd_err_q <= wd_err_d;
      end
   end
   assign watchdog_err = wd_err_q;
`else
   logic unused_wd;
   assign unused_wd    = ^{WATCHDOG_CYCLES, wd_set};
   assign watchdog_err = 1'b0;
`endif

   assign tx_start     = tx_start_q;
   assign tx_end_count = end_count_q;
   assign tx_prescaler = prescaler_q;
   assign busy         = (state_q != ST_IDLE);
   assign queue_level  = fifo_level;
   assign irq          = irq_q;

endmodule

// File: tb/tb_pulse_transmitter_job_scheduler.sv
// Directed bench for pulse_transmitter_job_scheduler; inputs and samples both on the falling edge.
module tb_pulse_transmitter_job_scheduler;

`ifdef PULSE_SCHED_WATCHDOG_EN
   localparam logic [19:0] WD = 20'd100;
`else
   localparam logic [19:0] WD = 20'hFFFFF;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid;
   logic [31:0] job_data;
   logic        job_ready;
   logic        abort;
   logic        tx_start;
   logic [6:0]  tx_end_count;
   logic [3:0]  tx_prescaler;
   logic        tx_done;
   logic        busy;
   logic [2:0]  queue_level;
   logic        irq;
   logic        irq_clear;
   logic        watchdog_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pulse_transmitter_job_scheduler #(.DEPTH(4), .WATCHDOG_CYCLES(WD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .job_valid    (job_valid),
      .job_data     (job_data),
      .job_ready    (job_ready),
      .abort        (abort),
      .tx_start     (tx_start),
      .tx_end_count (tx_end_count),
      .tx_prescaler (tx_prescaler),
      .tx_done      (tx_done),
      .busy         (busy),
      .queue_level  (queue_level),
      .irq          (irq),
      .irq_clear    (irq_clear),
      .watchdog_err (watchdog_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int e, input int p, input int r, input int g, input bit ie);
      logic [31:0] w;
      w = {ie, g[15:0], r[3:0], p[3:0], e[6:0]};
      return w;
   endfunction

   task automatic push_job(input logic [31:0] d);
      @(negedge clk);
      job_valid = 1'b1;
      job_data  = d;
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic wait_high();
      int n = 0;
      while (tx_start !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("wait_tx_start", tx_start, 1);
   endtask

   task automatic done_pulse();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   initial begin
      int rises, irq_rises, low_cnt, high_cnt;
      logic prev_ts, prev_irq;
      rst_n = 1'b0; job_valid = 1'b0; job_data = '0; abort = 1'b0;
      tx_done = 1'b0; irq_clear = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_irq", irq, 0);
      check("rst_level", queue_level, 0);
      check("rst_ready", job_ready, 1);
      check("rst_wd", watchdog_err, 0);
      check("rst_end", tx_end_count, 0);
      check("rst_presc", tx_prescaler, 0);

      // test 1: single job, latency and completion
      push_job(mk(5, 2, 0, 0, 1'b1));
      check("t1_level_after_push", queue_level, 1);
      check("t1_start_n", tx_start, 0);
      @(negedge clk);
      check("t1_busy_n1", busy, 1);
      check("t1_level_n1", queue_level, 0);
      @(negedge clk);
      check("t1_start_n2", tx_start, 0);
      check("t1_end_n2", tx_end_count, 5);
      check("t1_presc_n2", tx_prescaler, 2);
      @(negedge clk);
      check("t1_start_n3", tx_start, 1);
      repeat (9) @(negedge clk);
      tx_done = 1'b1;
      check("t1_start_before_done", tx_start, 1);
      @(negedge clk);
      tx_done = 1'b0;
      check("t1_start_after_done", tx_start, 0);
      check("t1_irq", irq, 1);
      check("t1_busy_end", busy, 0);
      check("t1_end_hold", tx_end_count, 5);
      @(negedge clk); irq_clear = 1'b1;
      @(negedge clk); irq_clear = 1'b0;
      check("t1_irq_cleared", irq, 0);
      done_pulse();
      check("t1_stray_done_irq", irq, 0);
      check("t1_stray_done_busy", busy, 0);

      // test 2: two repeats with gap 4, transmitter model answers 3 cycles after each start
      push_job(mk(9, 1, 2, 4, 1'b1));
      rises = 0; irq_rises = 0; low_cnt = 0; high_cnt = 0;
      prev_ts = 1'b0; prev_irq = irq;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tx_start && !prev_ts) begin
            rises++;
            if (rises > 1) check("t2_low_period", low_cnt, 5);
            low_cnt = 0;
         end
         if (!tx_start) low_cnt++;
         if (irq && !prev_irq) irq_rises++;
         if (tx_start) high_cnt++; else high_cnt = 0;
         tx_done = (high_cnt == 3);
         prev_ts  = tx_start;
         prev_irq = irq;
      end
      tx_done = 1'b0;
      check("t2_rises", rises, 3);
      check("t2_irq_once", irq_rises, 1);
      check("t2_busy_end", busy, 0);
      @(negedge clk); irq_clear = 1'b1;
      @(negedge clk); irq_clear = 1'b0;

      // test 3: overfill while busy, then in-order execution
      push_job(mk(1, 0, 0, 0, 1'b0));
      wait_high();
      for (int k = 2; k <= 5; k++) push_job(mk(k, 0, 0, 0, 1'b0));
      check("t3_level_full", queue_level, 4);
      check("t3_ready_full", job_ready, 0);
      @(negedge clk);
      job_valid = 1'b1;
      job_data  = mk(6, 0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      check("t3_no_push_full", queue_level, 4);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("t3_level_done", queue_level, 4);
      check("t3_ready_done", job_ready, 0);
      @(negedge clk);
      check("t3_level_pop", queue_level, 3);
      check("t3_ready_pop", job_ready, 1);
      @(negedge clk);
      job_valid = 1'b0;
      check("t3_level_refill", queue_level, 4);
      for (int k = 2; k <= 6; k++) begin
         wait_high();
         check("t3_order", tx_end_count, k);
         done_pulse();
      end
      @(negedge clk);
      check("t3_idle", busy, 0);
      check("t3_irq", irq, 0);

      // test 4: abort during WAIT_DONE with queued jobs, push and done in the same cycle
      push_job(mk(7, 3, 0, 0, 1'b1));
      wait_high();
      for (int k = 0; k < 3; k++) push_job(mk(10 + k, 0, 0, 0, 1'b1));
      check("t4_level_q", queue_level, 3);
      @(negedge clk);
      abort = 1'b1; job_valid = 1'b1; job_data = mk(20, 0, 0, 0, 1'b1); tx_done = 1'b1;
      @(negedge clk);
      abort = 1'b0; job_valid = 1'b0; tx_done = 1'b0;
      check("t4_tx_start", tx_start, 0);
      check("t4_level", queue_level, 0);
      check("t4_busy", busy, 0);
      check("t4_irq", irq, 0);
      repeat (4) @(negedge clk);
      check("t4_stays_idle", busy, 0);

      // test 5: irq set beats clear; gap=0 repeat gives a single low cycle
      push_job(mk(3, 1, 0, 0, 1'b1));
      wait_high();
      @(negedge clk);
      tx_done = 1'b1; irq_clear = 1'b1;
      @(negedge clk);
      tx_done = 1'b0; irq_clear = 1'b0;
      check("t5_irq_priority", irq, 1);
      @(negedge clk); irq_clear = 1'b1;
      @(negedge clk); irq_clear = 1'b0;
      check("t5_irq_clear", irq, 0);
      push_job(mk(4, 1, 1, 0, 1'b0));
      wait_high();
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("t5_gap0_low", tx_start, 0);
      @(negedge clk);
      check("t5_gap0_high", tx_start, 1);
      done_pulse();
      check("t5_done_busy", busy, 0);
      check("t5_done_irq", irq, 0);

      // test 6: watchdog
`ifdef PULSE_SCHED_WATCHDOG_EN
      push_job(mk(8, 0, 2, 0, 1'b0));
      push_job(mk(9, 0, 0, 0, 1'b0));
      wait_high();
      repeat (99) @(negedge clk);
      check("t6_before_timeout", tx_start, 1);
      check("t6_wd_before", watchdog_err, 0);
      @(negedge clk);
      check("t6_timeout_start", tx_start, 0);
      check("t6_wd_err", watchdog_err, 1);
      check("t6_wd_irq", irq, 1);
      wait_high();
      check("t6_next_job", tx_end_count, 9);
      @(negedge clk); irq_clear = 1'b1;
      @(negedge clk); irq_clear = 1'b0;
      check("t6_wd_clear", watchdog_err, 0);
`else
      push_job(mk(8, 0, 0, 0, 1'b1));
      wait_high();
      repeat (120) @(negedge clk);
      check("t6_no_wd", watchdog_err, 0);
      check("t6_hold_busy", busy, 1);
      check("t6_hold_start", tx_start, 1);
      check("t6_no_irq", irq, 0);
`endif
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("t6_abort_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
